// File: rtl/topk_sort_relu_stream_if.sv
// Stream bundle for the top-K sorter: scored (value, index) beats in, ranked beats out.
interface topk_sort_relu_stream_if #(
  parameter int K  = 8,
  parameter int DW = 32,
  parameter int IW = 32
);
  localparam int RW = $clog2(K) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [IW-1:0]        in_index;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]        out_index;
  logic [RW-1:0]        out_rank;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_rank, out_last
  );

  modport slave (
    input  in_valid, in_data, in_index, in_last, out_ready,
    output in_ready, out_valid, out_data, out_index, out_rank, out_last
  );
endinterface

// File: rtl/topk_sort_relu_stream.sv
// Streaming top-K selector with optional ReLU: one beat per cycle into a sorted register array,
// then the ranked list drains from registered outputs, stalling cleanly on out_ready.
module topk_sort_relu_stream #(
  parameter int K  = 8,
  parameter int DW = 32,
  parameter int IW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic asce,
  input  logic relu_en,
  topk_sort_relu_stream_if.slave s,
  output logic done,
  output logic busy
);
  localparam int RW = $clog2(K) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e               state_q, state_d;
  logic                 asce_q, asce_d;
  logic                 relu_q, relu_d;
  logic [RW-1:0]        fill_q, fill_d;
  logic [RW-1:0]        ptr_q, ptr_d;
  logic signed [DW-1:0] val_q [K];
  logic signed [DW-1:0] val_d [K];
  logic [IW-1:0]        idx_q [K];
  logic [IW-1:0]        idx_d [K];
  logic [K-1:0]         vld_q, vld_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0]        out_index_q, out_index_d;
  logic [RW-1:0]        out_rank_q, out_rank_d;

  logic signed [DW-1:0] in_v;
  logic signed [DW-1:0] carry_val;
  logic [IW-1:0]        carry_idx;
  logic                 carry_vld;
  logic                 found;
  logic                 hit;

  assign in_v = (relu_q && s.in_data[DW-1]) ? '0 : s.in_data;

  always_comb begin
    state_d     = state_q;
    asce_d      = asce_q;
    relu_d      = relu_q;
    fill_d      = fill_q;
    ptr_d       = ptr_q;
    val_d       = val_q;
    idx_d       = idx_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_rank_d  = out_rank_q;
    done_d      = 1'b0;
    found       = 1'b0;
    hit         = 1'b0;
    carry_val   = '0;
    carry_idx   = '0;
    carry_vld   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          asce_d  = asce;
          relu_d  = relu_en;
          vld_d   = '0;
          fill_d  = '0;
          ptr_d   = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (s.in_valid) begin
          // Strict compare places a new value after any equal entries, keeping ties in arrival order.
          for (int i = 0; i < K; i++) begin
            hit = !vld_q[i] || (asce_q ? (in_v < val_q[i]) : (in_v > val_q[i]));
            if (found) begin
              val_d[i] = carry_val;
              idx_d[i] = carry_idx;
              vld_d[i] = carry_vld;
            end else if (hit) begin
              val_d[i] = in_v;
              idx_d[i] = s.in_index;
              vld_d[i] = 1'b1;
              found    = 1'b1;
            end
            carry_val = val_q[i];
            carry_idx = idx_q[i];
            carry_vld = vld_q[i];
          end

          if (fill_q != RW'(K)) begin
            fill_d = fill_q + 1'b1;
          end

          // Preload rank 0 from the post-insert list so the first output beat has no bubble.
          if (s.in_last) begin
            state_d     = DRAIN;
            ptr_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = val_d[0];
            out_index_d = idx_d[0];
            out_rank_d  = '0;
            out_last_d  = (fill_d == RW'(1));
          end
        end
      end

      DRAIN: begin
        if (out_valid_q && s.out_ready) begin
          if (out_last_q) begin
            done_d      = 1'b1;
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            out_index_d = '0;
            out_rank_d  = '0;
          end else begin
            ptr_d      = ptr_q + 1'b1;
            out_rank_d = ptr_d;
            out_last_d = (ptr_d == fill_q - 1'b1);
            for (int i = 0; i < K; i++) begin
              if (RW'(i) == ptr_d) begin
                out_data_d  = val_q[i];
                out_index_d = idx_q[i];
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      asce_q      <= 1'b0;
      relu_q      <= 1'b0;
      fill_q      <= '0;
      ptr_q       <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_rank_q  <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < K; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      asce_q      <= asce_d;
      relu_q      <= relu_d;
      fill_q      <= fill_d;
      ptr_q       <= ptr_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_rank_q  <= out_rank_d;
      done_q      <= done_d;
      for (int i = 0; i < K; i++) begin
        val_q[i] <= val_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign s.in_ready  = (state_q == LOAD);
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_index = out_index_q;
  assign s.out_rank  = out_rank_q;
  assign s.out_last  = out_last_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_topk_sort_relu_stream.sv
// Bench for topk_sort_relu_stream: directed and random sets ranked by a selection-sort reference.
module tb_topk_sort_relu_stream;
  localparam int K  = 8;
  localparam int DW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic asce = 1'b0;
  logic relu_en = 1'b0;
  logic done;
  logic busy;

  topk_sort_relu_stream_if #(.K(K), .DW(DW), .IW(IW)) bus ();

  topk_sort_relu_stream #(.K(K), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .asce(asce), .relu_en(relu_en),
    .s(bus), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int in_vals[$];
  int in_idx[$];
  int exp_v[$];
  int exp_i[$];
  int ob_v[$];
  int ob_i[$];
  int ob_r[$];
  int ob_l[$];
  int hold_viol;
  int done_early;
  int done_seen;
  int post_valid;
  int done_after;
  int tmo;

  // Reference: relu, then repeatedly pick the best unused entry (earliest wins ties).
  task automatic model(input bit a, input bit r);
    int v[$];
    bit used[$];
    int n;
    n = in_vals.size();
    exp_v.delete();
    exp_i.delete();
    for (int i = 0; i < n; i++) begin
      v.push_back((r && in_vals[i] < 0) ? 0 : in_vals[i]);
      used.push_back(1'b0);
    end
    for (int k = 0; k < K && k < n; k++) begin
      int b;
      b = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (b < 0 || (a ? v[i] < v[b] : v[i] > v[b]))) b = i;
      used[b] = 1'b1;
      exp_v.push_back(v[b]);
      exp_i.push_back(in_idx[b]);
    end
  endtask

  task automatic rand_set(input int n, input int base);
    in_vals.delete();
    in_idx.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) in_vals.push_back(int'($urandom()));
      else in_vals.push_back(int'($urandom_range(0, 40)) - 20);
      in_idx.push_back(base + i);
    end
  endtask

  task automatic send_set(input bit a, input bit r, input bit gaps, input bit poke_start);
    int n;
    n = in_vals.size();
    @(negedge clk);
    asce = a;
    relu_en = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    asce = ~a;
    relu_en = ~r;
    for (int i = 0; i < n; i++) begin
      int wait_cyc;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data = int'($urandom());
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data = in_vals[i];
      bus.in_index = in_idx[i];
      bus.in_last = (i == n - 1);
      start = poke_start && (i == n / 2);
      wait_cyc = 0;
      while (!bus.in_ready && wait_cyc < 50) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (wait_cyc >= 50) tmo = 1;
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  // pat: 0 always ready, 1 ready pattern 1,0,0, 2 random. stop_after>0 returns after that many beats.
  task automatic collect(input int pat, input int stop_after);
    int cyc, pc, beats;
    bit stalled;
    int sv, si, sr, sl;
    ob_v.delete(); ob_i.delete(); ob_r.delete(); ob_l.delete();
    hold_viol = 0; done_early = 0; done_seen = 0; post_valid = 1; done_after = 1;
    cyc = 0; pc = 0; beats = 0; stalled = 0;
    sv = 0; si = 0; sr = 0; sl = 0;
    bus.out_ready = 1'b0;
    forever begin
      bit rdy;
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        tmo = 1;
        break;
      end
      if (done) done_early++;
      if (stalled && (bus.out_valid !== 1'b1 || int'(bus.out_data) != sv ||
          int'(bus.out_index) != si || int'(bus.out_rank) != sr || int'(bus.out_last) != sl))
        hold_viol++;
      stalled = 0;
      if (bus.out_valid) begin
        rdy = (pat == 0) ? 1'b1 : (pat == 1) ? (pc % 3 == 0) : 1'($urandom_range(0, 1));
        pc++;
        bus.out_ready = rdy;
        if (rdy) begin
          ob_v.push_back(int'(bus.out_data));
          ob_i.push_back(int'(bus.out_index));
          ob_r.push_back(int'(bus.out_rank));
          ob_l.push_back(int'(bus.out_last));
          beats++;
          if (bus.out_last) begin
            @(negedge clk);
            done_seen = done;
            post_valid = bus.out_valid;
            bus.out_ready = 1'b0;
            @(negedge clk);
            done_after = done;
            break;
          end
          if (stop_after > 0 && beats == stop_after) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            break;
          end
        end else begin
          stalled = 1;
          sv = int'(bus.out_data); si = int'(bus.out_index);
          sr = int'(bus.out_rank); sl = int'(bus.out_last);
        end
      end else begin
        bus.out_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", bus.out_last); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_done_busy got %b%b want 00", done, busy); end
    checks++; if (bus.out_data !== '0 || bus.out_index !== '0 || bus.out_rank !== '0) begin
      errors++; $display("FAIL rst_out_bus got %0d/%0d/%0d want 0/0/0", bus.out_data, bus.out_index, bus.out_rank);
    end
  endtask

  task automatic test_plan_asce;
    int ev[8] = '{-3, 0, 1, 2, 4, 5, 6, 7};
    int ei[8] = '{1, 7, 3, 5, 8, 0, 9, 4};
    int iv[10] = '{5, -3, 9, 1, 7, 2, 8, 0, 4, 6};
    in_vals.delete(); in_idx.delete();
    for (int i = 0; i < 10; i++) begin in_vals.push_back(iv[i]); in_idx.push_back(i); end
    send_set(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL plan_busy got %b want 1", busy); end
    collect(0, 0);
    checks++; if (ob_v.size() != 8) begin errors++; $display("FAIL plan_count got %0d want 8", ob_v.size()); end
    for (int k = 0; k < 8 && k < ob_v.size(); k++) begin
      checks++;
      if (ob_v[k] != ev[k] || ob_i[k] != ei[k] || ob_r[k] != k || ob_l[k] != (k == 7)) begin
        errors++;
        $display("FAIL plan_beat%0d got v=%0d i=%0d r=%0d l=%0d want v=%0d i=%0d r=%0d l=%0d",
                 k, ob_v[k], ob_i[k], ob_r[k], ob_l[k], ev[k], ei[k], k, (k == 7));
      end
    end
    checks++;
    if (done_seen != 1 || done_after != 0 || post_valid != 0 || done_early != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL plan_done got seen=%0d after=%0d pv=%0d early=%0d busy=%b want 1 0 0 0 0",
               done_seen, done_after, post_valid, done_early, busy);
    end
  endtask

  task automatic test_relu_and_ties;
    for (int t = 0; t < 2; t++) begin
      bit a;
      bit r;
      in_vals.delete(); in_idx.delete();
      if (t == 0) begin
        a = 1'b0; r = 1'b1;
        in_vals = '{-5, -2, 3, -7}; in_idx = '{0, 1, 2, 3};
      end else begin
        a = 1'b1; r = 1'b0;
        in_vals = '{4, 4, 4}; in_idx = '{10, 11, 12};
      end
      model(a, r);
      send_set(a, r, 1'b0, 1'b0);
      collect(0, 0);
      checks++;
      if (ob_v.size() != exp_v.size()) begin
        errors++; $display("FAIL set%0d_count got %0d want %0d", t, ob_v.size(), exp_v.size());
      end
      for (int k = 0; k < ob_v.size() && k < exp_v.size(); k++) begin
        checks++;
        if (ob_v[k] != exp_v[k] || ob_i[k] != exp_i[k] || ob_r[k] != k || ob_l[k] != (k == exp_v.size() - 1)) begin
          errors++;
          $display("FAIL set%0d_beat%0d got v=%0d i=%0d r=%0d l=%0d want v=%0d i=%0d r=%0d",
                   t, k, ob_v[k], ob_i[k], ob_r[k], ob_l[k], exp_v[k], exp_i[k], k);
        end
      end
      checks++; if (done_seen != 1) begin errors++; $display("FAIL set%0d_done got %0d want 1", t, done_seen); end
    end
  endtask

  task automatic test_backpressure;
    rand_set(13, 100);
    model(1'b0, 1'b0);
    send_set(1'b0, 1'b0, 1'b1, 1'b0);
    collect(1, 0);
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", hold_viol); end
    checks++; if (ob_v.size() != K) begin errors++; $display("FAIL bp_count got %0d want %0d", ob_v.size(), K); end
    for (int k = 0; k < ob_v.size() && k < exp_v.size(); k++) begin
      checks++;
      if (ob_v[k] != exp_v[k] || ob_i[k] != exp_i[k] || ob_r[k] != k) begin
        errors++;
        $display("FAIL bp_beat%0d got v=%0d i=%0d r=%0d want v=%0d i=%0d r=%0d",
                 k, ob_v[k], ob_i[k], ob_r[k], exp_v[k], exp_i[k], k);
      end
    end
  endtask

  task automatic test_single_then_remode;
    in_vals = '{42}; in_idx = '{7};
    send_set(1'b1, 1'b1, 1'b0, 1'b0);
    collect(2, 0);
    checks++;
    if (ob_v.size() != 1 || ob_v[0] != 42 || ob_i[0] != 7 || ob_r[0] != 0 || ob_l[0] != 1) begin
      errors++; $display("FAIL single_beat got n=%0d want one beat 42 idx7 rank0 last", ob_v.size());
    end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_seen); end
    in_vals = '{-9, -1, -4, -20, -2}; in_idx = '{0, 1, 2, 3, 4};
    model(1'b0, 1'b0);
    send_set(1'b0, 1'b0, 1'b0, 1'b0);
    collect(0, 0);
    checks++; if (ob_v.size() != 5) begin errors++; $display("FAIL remode_count got %0d want 5", ob_v.size()); end
    for (int k = 0; k < ob_v.size() && k < exp_v.size(); k++) begin
      checks++;
      if (ob_v[k] != exp_v[k] || ob_i[k] != exp_i[k]) begin
        errors++; $display("FAIL remode_beat%0d got v=%0d i=%0d want v=%0d i=%0d", k, ob_v[k], ob_i[k], exp_v[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_random_sets;
    for (int t = 0; t < 12; t++) begin
      bit a;
      bit r;
      a = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      rand_set(int'($urandom_range(1, 20)), t * 100);
      model(a, r);
      send_set(a, r, 1'b1, 1'b1);
      collect(2, 0);
      checks++;
      if (ob_v.size() != exp_v.size() || hold_viol != 0 || done_seen != 1) begin
        errors++;
        $display("FAIL rand%0d_shape got n=%0d hold=%0d done=%0d want n=%0d hold=0 done=1",
                 t, ob_v.size(), hold_viol, done_seen, exp_v.size());
      end
      for (int k = 0; k < ob_v.size() && k < exp_v.size(); k++) begin
        checks++;
        if (ob_v[k] != exp_v[k] || ob_i[k] != exp_i[k] || ob_r[k] != k || ob_l[k] != (k == exp_v.size() - 1)) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got v=%0d i=%0d r=%0d l=%0d want v=%0d i=%0d r=%0d",
                   t, k, ob_v[k], ob_i[k], ob_r[k], ob_l[k], exp_v[k], exp_i[k], k);
        end
      end
    end
  endtask

  task automatic test_reset_in_drain;
    int dn;
    rand_set(10, 500);
    send_set(1'b1, 1'b0, 1'b0, 1'b0);
    collect(0, 3);
    checks++; if (ob_v.size() != 3) begin errors++; $display("FAIL abort_pre got %0d beats want 3", ob_v.size()); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== '0 ||
        bus.out_index !== '0 || bus.out_rank !== '0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got v=%b l=%b d=%0d i=%0d r=%0d busy=%b want all 0",
               bus.out_valid, bus.out_last, bus.out_data, bus.out_index, bus.out_rank, busy);
    end
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) dn++;
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", dn); end
    rand_set(6, 600);
    model(1'b1, 1'b1);
    send_set(1'b1, 1'b1, 1'b0, 1'b0);
    collect(0, 0);
    checks++; if (ob_v.size() != exp_v.size()) begin errors++; $display("FAIL after_abort_count got %0d want %0d", ob_v.size(), exp_v.size()); end
    for (int k = 0; k < ob_v.size() && k < exp_v.size(); k++) begin
      checks++;
      if (ob_v[k] != exp_v[k] || ob_i[k] != exp_i[k]) begin
        errors++; $display("FAIL after_abort_beat%0d got v=%0d i=%0d want v=%0d i=%0d", k, ob_v[k], ob_i[k], exp_v[k], exp_i[k]);
      end
    end
  endtask

  initial begin
    tmo = 0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_index = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_plan_asce;
    test_relu_and_ties;
    test_backpressure;
    test_single_then_remode;
    test_random_sets;
    test_reset_in_drain;
    checks++;
    if (tmo != 0) begin errors++; $display("FAIL handshake_timeout got %0d want 0", tmo); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got expired want completion");
    $fatal(1);
  end
endmodule

// File: doc/topk_sort_relu_stream.md
Name: topk_sort_relu_stream

Overview:
- Clocked, parametrised successor to the combinational top-K sorter.
- Accepts a stream of (value, index) pairs over a valid/ready handshake and optionally applies ReLU before ranking.
- Keeps the K best entries in a parallel insertion register array, in ascending or descending order.
- After the last input it streams the ranked list out over a second valid/ready handshake. Sits between the distance/score datapath and the classifier/vote stage.

Parameters:
- K, 8, number of entries kept (1..32).
- DW, 32, data width; values are two's-complement signed.
- IW, 32, index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches mode and clears the list (IDLE only).
- asce  in  1  sampled on start; 1 = keep K smallest ascending, 0 = keep K largest descending.
- relu_en  in  1  sampled on start; 1 = negative inputs are clamped to 0 before ranking.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DW  signed value.
- in_index  in  IW  index tag carried with the value.
- in_last  in  1  marks the final input beat of the set.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DW  ranked value (post-ReLU).
- out_index  out  IW  index of ranked value.
- out_rank  out  $clog2(K)+1  position 0..K-1, where 0 is best.
- out_last  out  1  final output beat.
- done  out  1  one-cycle pulse after the final output handshake.
- busy  out  1  high in LOAD or DRAIN.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All entry valid bits are cleared; data and index registers are cleared to 0.
  - in_ready, out_valid, out_last, done and busy are 0; out_data, out_index and out_rank are 0.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - in_ready=0.
  - On start=1, latch asce and relu_en, clear all entry valid bits and the fill count, and go to LOAD next cycle.
- LOAD:
  - in_ready=1.
  - For each accepted beat, v = (relu_en && in_data<0) ? 0 : in_data.
  - Insert position p = first slot i where the slot is empty, or (asce && v < value[i]), or (!asce && v > value[i]). Comparison is signed.
  - Ties go after existing equal entries, so ordering is stable by arrival.
  - Slots p..K-2 shift down one position; slot K-1 is dropped.
  - If no such p exists, the beat is discarded.
  - The list is updated at the clock edge of the handshake; one beat per cycle, sustained, with no bubbles.
  - fill = min(fill+1, K).
  - When the beat with in_last is accepted, go to DRAIN next cycle.
  - start is ignored in LOAD.
- DRAIN:
  - in_ready=0.
  - out_valid=1 while ptr < fill; ptr starts at 0.
  - Outputs are registered: out_data=value[ptr], out_index=index[ptr], out_rank=ptr.
  - out_last=1 when ptr==fill-1.
  - Outputs hold stable while out_valid & !out_ready.
  - On a handshake ptr increments.
  - After the out_last handshake: done=1 for one cycle, return to IDLE, out_valid=0.
  - If fill==0 (impossible; in_last always carries data, fill>=1), not a reachable case.
  - start is ignored in DRAIN.
- Fewer than K inputs: only fill entries are output. Empty slots are never emitted.
- Reset mid-LOAD/DRAIN: immediate abort; no done pulse.
- busy = (state != IDLE).

Test Plan:
- asce=1, relu_en=0, K=8; inputs 5,-3,9,1,7,2,8,0,4,6 with idx 0..9, last on idx 9 -> out -3(1),0(7),1(3),2(5),4(8),5(0),6(9),7(4); out_last on rank 7; done one cycle after.
- asce=0, relu_en=1; inputs -5,-2,3,-7 idx 0..3 -> fill=4; out 3(2),0(0),0(1),0(3) in that order (stable ties); out_last on rank 3.
- asce=1, inputs 4,4,4 idx 10,11,12 -> output order idx 10,11,12; out_last with rank 2.
- Backpressure: out_ready toggles 1,0,0,1,... -> each beat held unchanged while stalled; no beat lost or duplicated; rank sequence 0..K-1.
- Single input 42 with in_last -> one output beat 42 with rank 0 and out_last=1; done pulse; then a new start with a different mode sorts correctly with no stale entries.
- Assert rst=0 during DRAIN after 3 beats -> all outputs 0 immediately, state IDLE, no done; next start and load behave as from power-up.
